ov7670_reg_sequencer: RTL and testbench
=======================================

Name: ov7670_reg_sequencer

Overview:
Parametrised OV7670 configuration sequencer. It walks an internal register table and issues 16-bit {reg,value} commands to the SCCB master over a valid/ready handshake. After a soft reset it inserts a settling delay, then writes the whole table. Manual exposure is split across the COM1, AECH and AECHH registers, and can be rewritten at runtime without replaying the table. One instance per camera (left/right) sits between the top-level control and the SCCB master.

Parameters:
CLK_FREQ_HZ, 25000000, clk frequency; used to size the delay counter.
RESET_DELAY_MS, 1, wait after the 0x1280 soft reset, in ms.
IDX_W, 8, table index width; the table must fit in 2**IDX_W entries.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
resend  in  1  1-cycle pulse: restart the sequence from index 0
exposure  in  16  manual exposure value; bits [15:10]→AECHH[5:0], [9:2]→AECH, [1:0]→COM1[1:0]
exp_update  in  1  1-cycle pulse: rewrite the three exposure registers
cmd_ready  in  1  SCCB master can accept a command
cmd_valid  out  1  command is valid
command  out  16  {reg_addr[7:0], reg_data[7:0]}
busy  out  1  a sequence or an exposure update is in progress
finished  out  1  table complete and no update pending

Behaviour:
- Reset values: cmd_valid=0, command=16'hFFFF, busy=0, finished=0, index=0, state=IDLE, exposure latch=16'h0000, pending flag=0.
- Leaving reset: the block stays in IDLE until the first resend. It does not auto-start.
- Table, indices 0..60:
  - 0: 1280
  - 1: DELAY marker
  - 2..6: 1200, 1100, 0C00, 3E00, 8C00
  - 7: {8'h04, 6'b0, exp[1:0]}
  - 8: {8'h10, exp[9:2]}
  - 9: {8'h07, 2'b0, exp[15:10]}
  - 10..59: the team's standard 50-entry RGB565 list (4010 through 4200, including 138e, which disables auto-AEC)
  - 60: END marker
  - 59 commands are issued in total.
- exp is the internal latch. It captures exposure on resend and on exp_update.
- States:
  - IDLE → LOAD on resend.
  - LOAD: fetch table[index], 1 cycle.
    - Normal entry: drive command, set cmd_valid, go to SEND.
    - DELAY marker: load the counter with CLK_FREQ_HZ/1000*RESET_DELAY_MS-1, go to WAIT.
    - END marker: go to DONE.
  - SEND: hold command and cmd_valid stable until cmd_valid&&cmd_ready. On that cycle clear cmd_valid, index+1, go to LOAD. The back-to-back rate is therefore one command per 2 cycles minimum.
  - WAIT: decrement to 0, then index+1 and go to LOAD. No commands are issued during WAIT.
  - DONE: finished=1, busy=0, command=16'hFFFF.
    - exp_update (or the pending flag) → EXP state with sub-index 0..2, issuing 04, 10, 07 entries with the same SEND handshake, then back to DONE.
    - finished=0 during EXP.
- busy=1 in LOAD, SEND, WAIT and EXP.
- Boundary conditions:
  - resend in any state, including mid-handshake or WAIT: on the next edge cmd_valid=0, index=0, pending flag cleared, go to LOAD. resend wins over a same-cycle handshake.
  - exp_update outside DONE/EXP: latch exposure, set pending. The flag is serviced on entering DONE; finished is held at 0 while pending is set.
  - exp_update during EXP: relatch exposure, set pending, restart the 3-write update after the current one completes.
  - A delay count of 0 (RESET_DELAY_MS=0) means WAIT lasts 1 cycle.
  - Index never wraps: END is reached before 2**IDX_W.
  - reset asserted at any time: immediate return to reset values.

Optional Feature:
- Macro: OV7670_SEQ_CRC_EN.
- When defined: add output crc_ok (1 bit). A CRC-8 (poly 0x07, init 0x00) runs over every accepted command, high byte then low byte, 2 bytes per cycle combinationally. On END the result is compared with a constant holding the precomputed golden CRC for exposure=0. crc_ok is a sticky 1 when it matches and exposure latch==0; it clears on resend or reset.
- When undefined: no port and no CRC logic.

Test Plan:
- Reset, then resend with cmd_ready tied 1 and exposure=16'h0000 → first command 1280, cmd_valid low for 25000 cycles, then 1200. Exactly 59 handshakes, then finished=1 with command=FFFF.
- exposure=16'hABCD at resend → entries 7/8/9 read 0401, 10F3, 072A.
- cmd_ready held 0 for 10 cycles during entry 4 → command stays 0C00 and cmd_valid stays 1, with no index advance.
- In DONE, exposure=16'h0007 plus exp_update → exactly 3 commands 0403, 1001, 0700. finished is low during them, then high.
- resend during WAIT and again mid-SEND at index 30 → cmd_valid drops next cycle, the sequence restarts at 1280, and the full 59 commands are reissued.
- exp_update at index 20 → no extra writes until END; then 3 exposure writes with the latched value before finished=1.

Source files
------------

// File: rtl/ov7670_reg_sequencer.sv
// ov7670_reg_sequencer: walks the OV7670 register table and issues {reg,value} commands to the SCCB master
// Ports: clk, reset (async, active-high); resend / exp_update 1-cycle pulses; exposure[15:0] manual exposure;
//        cmd_ready / cmd_valid / command[15:0] SCCB command handshake; busy, finished status.
//        Optional macro OV7670_SEQ_CRC_EN adds crc_ok (sticky CRC-8 check of the issued table).
module ov7670_reg_sequencer #(
   parameter int CLK_FREQ_HZ    = 25000000,
   parameter int RESET_DELAY_MS = 1,
   parameter int IDX_W          = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        resend,
   input  logic [15:0] exposure,
   input  logic        exp_update,
   input  logic        cmd_ready,
   output logic        cmd_valid,
   output logic [15:0] command,
   output logic        busy,
   output logic        finished
`ifdef OV7670_SEQ_CRC_EN
   ,
   output logic        crc_ok
`endif
);
   localparam int DLY_RAW = CLK_FREQ_HZ / 1000 * RESET_DELAY_MS;
   localparam int DLY = DLY_RAW > 0 ? DLY_RAW - 1 : 0;
   localparam int CW = DLY > 0 ? $clog2(DLY + 1) : 1;
   localparam logic [15:0] M_DELAY = 16'hFFF0;
   localparam logic [15:0] M_END = 16'hFFFF;
   typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, DONE, EXP} state_t;
   // Table entries 7..9 are built from the exposure latch so runtime updates reuse them.
   function automatic logic [15:0] rom(input logic [IDX_W-1:0] i, input logic [15:0] e);
      logic [15:0] r;
      case (int'(i))
         0: r = 16'h1280;  1: r = M_DELAY;  2: r = 16'h1200;  3: r = 16'h1100;
         4: r = 16'h0C00;  5: r = 16'h3E00;  6: r = 16'h8C00;
         7: r = {8'h04, 6'b0, e[1:0]};
         8: r = {8'h10, e[9:2]};
         9: r = {8'h07, 2'b0, e[15:10]};
         10: r = 16'h4010; 11: r = 16'h3A04; 12: r = 16'h3DC0; 13: r = 16'h1714; 14: r = 16'h1802;
         15: r = 16'h3203; 16: r = 16'h1903; 17: r = 16'h1A7B; 18: r = 16'h030A; 19: r = 16'h0F41;
         20: r = 16'h1E00; 21: r = 16'h330B; 22: r = 16'h3C78; 23: r = 16'h6900; 24: r = 16'h7400;
         25: r = 16'hB084; 26: r = 16'hB10C; 27: r = 16'hB20E; 28: r = 16'hB380; 29: r = 16'h7A20;
         30: r = 16'h7B10; 31: r = 16'h7C1E; 32: r = 16'h7D35; 33: r = 16'h7E5A; 34: r = 16'h7F69;
         35: r = 16'h8076; 36: r = 16'h8180; 37: r = 16'h8288; 38: r = 16'h838F; 39: r = 16'h8496;
         40: r = 16'h85A3; 41: r = 16'h86AF; 42: r = 16'h87C4; 43: r = 16'h88D7; 44: r = 16'h89E8;
         45: r = 16'h138E; 46: r = 16'h0000; 47: r = 16'h0D40; 48: r = 16'h1418; 49: r = 16'hA505;
         50: r = 16'hAB07; 51: r = 16'h2495; 52: r = 16'h2533; 53: r = 16'h26E3; 54: r = 16'h9F78;
         55: r = 16'hA068; 56: r = 16'hA103; 57: r = 16'hA6D8; 58: r = 16'hA7D8; 59: r = 16'h4200;
         default: r = M_END;
      endcase
      return r;
   endfunction
   state_t           state_q;
   logic [IDX_W-1:0] idx_q;
   logic [CW-1:0]    cnt_q;
   logic [15:0]      exp_q;
   logic             pend_q;
   logic [1:0]       sub_q;
   logic [15:0]      entry;
   logic             hs;
   assign entry = rom(idx_q, exp_q);
   assign hs = cmd_valid && cmd_ready;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         cnt_q     <= '0;
         exp_q     <= '0;
         pend_q    <= 1'b0;
         sub_q     <= '0;
         cmd_valid <= 1'b0;
         command   <= 16'hFFFF;
         busy      <= 1'b0;
         finished  <= 1'b0;
      end else if (resend) begin
         // resend overrides any handshake or wait in flight
         state_q   <= LOAD;
         idx_q     <= '0;
         exp_q     <= exposure;
         pend_q    <= 1'b0;
         cmd_valid <= 1'b0;
         busy      <= 1'b1;
         finished  <= 1'b0;
      end else begin
         if (exp_update) exp_q <= exposure;
         if (exp_update && state_q != DONE) pend_q <= 1'b1;
         case (state_q)
            LOAD:
               if (entry == M_END) begin
                  state_q  <= DONE;
                  command  <= 16'hFFFF;
                  busy     <= 1'b0;
                  finished <= !(pend_q || exp_update);
               end else if (entry == M_DELAY) begin
                  state_q <= WAIT;
                  cnt_q   <= CW'(DLY);
               end else begin
                  state_q   <= SEND;
                  command   <= entry;
                  cmd_valid <= 1'b1;
               end
            SEND:
               if (hs) begin
                  cmd_valid <= 1'b0;
                  idx_q     <= idx_q + 1'b1;
                  state_q   <= LOAD;
               end
            WAIT:
               if (cnt_q == '0) begin
                  idx_q   <= idx_q + 1'b1;
                  state_q <= LOAD;
               end else cnt_q <= cnt_q - 1'b1;
            DONE:
               if (exp_update || pend_q) begin
                  state_q  <= EXP;
                  sub_q    <= '0;
                  pend_q   <= 1'b0;
                  busy     <= 1'b1;
                  finished <= 1'b0;
               end
            EXP:
               // alternate fetch / handshake over table entries 7, 8, 9; DONE picks up any new pending update
               if (!cmd_valid) begin
                  command   <= rom(IDX_W'(7) + IDX_W'(sub_q), exp_q);
                  cmd_valid <= 1'b1;
               end else if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  if (sub_q == 2'd2) begin
                     state_q  <= DONE;
                     command  <= 16'hFFFF;
                     busy     <= 1'b0;
                     finished <= !(pend_q || exp_update);
                  end else sub_q <= sub_q + 1'b1;
               end
            default: ;
         endcase
      end
   end
`ifdef OV7670_SEQ_CRC_EN
   // MSB-first CRC-8 (poly 0x07) over one 16-bit command, i.e. high byte then low byte
   function automatic logic [7:0] crc8(input logic [7:0] c, input logic [15:0] d);
      logic [7:0] r;
      r = c;
      for (int b = 15; b >= 0; b--) r = (r[7] ^ d[b]) ? {r[6:0], 1'b0} ^ 8'h07 : {r[6:0], 1'b0};
      return r;
   endfunction
   function automatic logic [7:0] golden();
      logic [7:0]  r;
      logic [15:0] e;
      logic        stop;
      r = 8'h00;
      stop = 1'b0;
      for (int i = 0; i < 2 ** IDX_W; i++) begin
         e = rom(IDX_W'(i), 16'h0000);
         if (e == M_END) stop = 1'b1;
         if (!stop && e != M_DELAY) r = crc8(r, e);
      end
      return r;
   endfunction
   localparam logic [7:0] CRC_GOLD = golden();
   logic [7:0] crc_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         crc_q  <= '0;
         crc_ok <= 1'b0;
      end else if (resend) begin
         crc_q  <= '0;
         crc_ok <= 1'b0;
      end else begin
         if (hs) crc_q <= crc8(crc_q, command);
         if (state_q == LOAD && entry == M_END && crc_q == CRC_GOLD && exp_q == '0) crc_ok <= 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_ov7670_reg_sequencer.sv
// tb_ov7670_reg_sequencer: directed self-checking bench for ov7670_reg_sequencer
module tb_ov7670_reg_sequencer;
   localparam int CLK_HZ = 2000000;
   logic        clk = 1'b0;
   logic        reset, resend, exp_update, cmd_ready;
   logic [15:0] exposure;
   logic        cmd_valid, busy, finished, cmd_valid0, busy0, finished0;
   logic [15:0] command, command0;
   int          tests = 0, fails = 0, n = 0, n0 = 0, cyc = 0, t, k;
   logic        fhs = 1'b0;
   logic [15:0] log_q [0:127];
   int          ts [0:127];
   int          ts0 [0:127];
`ifdef OV7670_SEQ_CRC_EN
   logic        crc_ok, crc_ok0;
`endif
   always #5 clk = ~clk;
   ov7670_reg_sequencer #(.CLK_FREQ_HZ(CLK_HZ), .RESET_DELAY_MS(1), .IDX_W(8)) dut (
      .clk(clk), .reset(reset), .resend(resend), .exposure(exposure), .exp_update(exp_update),
      .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .command(command), .busy(busy), .finished(finished)
`ifdef OV7670_SEQ_CRC_EN
      , .crc_ok(crc_ok)
`endif
   );
   ov7670_reg_sequencer #(.CLK_FREQ_HZ(CLK_HZ), .RESET_DELAY_MS(0), .IDX_W(8)) dut0 (
      .clk(clk), .reset(reset), .resend(resend), .exposure(exposure), .exp_update(exp_update),
      .cmd_ready(cmd_ready), .cmd_valid(cmd_valid0), .command(command0), .busy(busy0), .finished(finished0)
`ifdef OV7670_SEQ_CRC_EN
      , .crc_ok(crc_ok0)
`endif
   );
   always @(posedge clk) begin
      cyc++;
      if (!reset && !resend && cmd_valid && cmd_ready) begin
         if (n < 128) begin
            log_q[n] = command;
            ts[n] = cyc;
         end
         n++;
         fhs = fhs | finished;
      end
      if (!reset && !resend && cmd_valid0 && cmd_ready) begin
         if (n0 < 128) ts0[n0] = cyc;
         n0++;
      end
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(negedge clk);
   endtask
   task automatic pulse_resend();
      n = 0;
      n0 = 0;
      fhs = 1'b0;
      resend = 1'b1;
      tick();
      resend = 1'b0;
   endtask
   task automatic wait_fin(input string tag);
      t = 0;
      while (!finished && t < 20000) begin
         tick();
         t++;
      end
      chk({tag, " finished"}, finished, 1'b1);
   endtask
   task automatic wait_n(input int m);
      t = 0;
      while (n < m && t < 20000) begin
         tick();
         t++;
      end
      chk("wait_n", n >= m, 1'b1);
   endtask
   initial begin
      reset = 1'b1;
      resend = 1'b0;
      exp_update = 1'b0;
      cmd_ready = 1'b1;
      exposure = 16'h0000;
      repeat (3) tick();
      chk("rst cmd_valid", cmd_valid, 1'b0);
      chk("rst command", command, 16'hFFFF);
      chk("rst busy", busy, 1'b0);
      chk("rst finished", finished, 1'b0);
      reset = 1'b0;
      repeat (5) tick();
      chk("idle busy", busy, 1'b0);
      chk("idle valid", cmd_valid, 1'b0);
      chk("idle n", n, 0);
      pulse_resend();
      chk("run busy", busy, 1'b1);
      wait_fin("full");
      chk("full n", n, 59);
      chk("full command", command, 16'hFFFF);
      chk("full busy", busy, 1'b0);
      chk("full cmd0", log_q[0], 16'h1280);
      chk("full cmd1", log_q[1], 16'h1200);
      chk("delay gap", ts[1] - ts[0], 2003);
      chk("delay0 gap", ts0[1] - ts0[0], 4);
      chk("full exp7", log_q[6], 16'h0400);
      chk("full exp8", log_q[7], 16'h1000);
      chk("full exp9", log_q[8], 16'h0700);
      chk("full rgb first", log_q[9], 16'h4010);
      chk("full com8", log_q[44], 16'h138E);
      chk("full last", log_q[58], 16'h4200);
      chk("dut0 n", n0, 59);
      chk("dut0 finished", finished0, 1'b1);
      chk("dut0 busy", busy0, 1'b0);
      chk("dut0 command", command0, 16'hFFFF);
      repeat (5) tick();
      chk("no wrap n", n, 59);
      chk("no wrap finished", finished, 1'b1);
      exposure = 16'hABCD;
      pulse_resend();
      exposure = 16'h0000;
      wait_fin("abcd");
      chk("abcd n", n, 59);
      chk("abcd com1", log_q[6], 16'h0401);
      chk("abcd aech", log_q[7], 16'h10F3);
      chk("abcd aechh", log_q[8], 16'h072A);
      pulse_resend();
      t = 0;
      while (!(cmd_valid && command == 16'h0C00) && t < 5000) begin
         tick();
         t++;
      end
      chk("bp reach", cmd_valid && command == 16'h0C00, 1'b1);
      cmd_ready = 1'b0;
      k = n;
      repeat (10) begin
         tick();
         chk("bp command", command, 16'h0C00);
         chk("bp valid", cmd_valid, 1'b1);
      end
      chk("bp n", n, 3);
      chk("bp n hold", n, k);
      cmd_ready = 1'b1;
      wait_fin("bp");
      chk("bp total", n, 59);
      chk("bp entry4", log_q[3], 16'h0C00);
      chk("bp entry5", log_q[4], 16'h3E00);
      exposure = 16'h0007;
      n = 0;
      fhs = 1'b0;
      exp_update = 1'b1;
      tick();
      exp_update = 1'b0;
      exposure = 16'h0000;
      chk("upd finished low", finished, 1'b0);
      chk("upd busy", busy, 1'b1);
      wait_fin("upd");
      chk("upd n", n, 3);
      chk("upd com1", log_q[0], 16'h0403);
      chk("upd aech", log_q[1], 16'h1001);
      chk("upd aechh", log_q[2], 16'h0700);
      chk("upd fin at hs", fhs, 1'b0);
      chk("upd command", command, 16'hFFFF);
      pulse_resend();
      wait_n(1);
      repeat (10) tick();
      chk("wait busy", busy, 1'b1);
      chk("wait valid", cmd_valid, 1'b0);
      chk("wait n", n, 1);
      pulse_resend();
      wait_n(1);
      chk("rewait cmd0", log_q[0], 16'h1280);
      t = 0;
      while (!(cmd_valid && command == 16'h7B10) && t < 5000) begin
         tick();
         t++;
      end
      chk("mid reach", cmd_valid && command == 16'h7B10, 1'b1);
      cmd_ready = 1'b0;
      tick();
      chk("mid n", n, 29);
      n = 0;
      fhs = 1'b0;
      cmd_ready = 1'b1;
      resend = 1'b1;
      tick();
      resend = 1'b0;
      chk("mid valid drop", cmd_valid, 1'b0);
      wait_fin("mid");
      chk("mid total", n, 59);
      chk("mid cmd0", log_q[0], 16'h1280);
      chk("mid cmd29", log_q[29], 16'h7B10);
      chk("mid last", log_q[58], 16'h4200);
      pulse_resend();
      wait_n(19);
      exposure = 16'h1234;
      exp_update = 1'b1;
      tick();
      exp_update = 1'b0;
      exposure = 16'h0000;
      wait_fin("pend");
      chk("pend n", n, 62);
      chk("pend old exp", log_q[8], 16'h0700);
      chk("pend penult", log_q[57], 16'hA7D8);
      chk("pend last", log_q[58], 16'h4200);
      chk("pend com1", log_q[59], 16'h0400);
      chk("pend aech", log_q[60], 16'h108D);
      chk("pend aechh", log_q[61], 16'h0704);
      chk("pend fin at hs", fhs, 1'b0);
      chk("pend busy", busy, 1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
